// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, state
// encoding, datapath select codes and the DECODE dispatch function.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_RWB,
        S_BRANCH,
        S_JUMP,
        S_ADDI_EX,
        S_ADDI_WB,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REGB    = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_source_e;

    // Where DECODE goes for a given opcode; disabled opcodes count as illegal.
    function automatic state_e decode_target(input logic [5:0] opc,
                                             input bit en_addi,
                                             input bit en_jump);
        state_e nxt;
        case (opc)
            OP_RTYPE:     nxt = S_EXEC;
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_BEQ:       nxt = S_BRANCH;
            OP_ADDI:      nxt = en_addi ? S_ADDI_EX : S_HALT;
            OP_J:         nxt = en_jump ? S_JUMP : S_HALT;
            default:      nxt = S_HALT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register with sticky illegal flag and a
// saturating retired-instruction counter, plus a state/mem_ready output decode.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int OPC_LSB = 26,
    parameter int CNT_W   = 16,
    parameter bit EN_ADDI = 1'b1,
    parameter bit EN_JUMP = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instrWord,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemToReg,
    output logic               RegWrite,
    output logic               RegDest,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               illegal,
    output logic [CNT_W-1:0]   instr_count
);

    state_e     state;
    logic [5:0] opcode;
    logic       unused_instr_bits;

    assign opcode            = instrWord[OPC_LSB +: 6];
    assign unused_instr_bits = ^instrWord;

    // NOTE: state-holding assignments are non-blocking so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                S_FETCH:   if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    state <= decode_target(opcode, EN_ADDI, EN_JUMP);
                    if (decode_target(opcode, EN_ADDI, EN_JUMP) == S_HALT)
                        illegal <= 1'b1;
                end
                S_MEMADR:  state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (mem_ready) state <= S_MEMWB;
                S_MEMWR:   if (mem_ready) state <= S_FETCH;
                S_EXEC:    state <= S_RWB;
                S_ADDI_EX: state <= S_ADDI_WB;
                S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB:
                           state <= S_FETCH;
                S_HALT:    state <= S_HALT;
                default:   state <= S_FETCH;
            endcase

            // Every path back to FETCH retires exactly one instruction.
            if (((state inside {S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB}) ||
                 (state == S_MEMWR && mem_ready)) &&
                (instr_count != {CNT_W{1'b1}}))
                instr_count <= instr_count + 1'b1;
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDest     = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REGB;
        ALUOp       = ALU_ADD;
        PCSource    = PCSRC_ALU;
        // Gating on rst_n keeps FETCH's MemRead off while reset is held.
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE:  ALUSrcB = SRCB_IMM_SH2;
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALU_FUNCT;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    RegDest  = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                end
                S_ADDI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_ADDI_WB: RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into its
// expected per-cycle control trace and compared on the falling clock edge.
module tb_multicycle_control;

    localparam int INSTR_W = 32;

    typedef struct {
        bit          mr;
        logic [15:0] ctrl;
        bit          ill;
    } cyc_t;

    logic               clk;
    logic               rst_n;
    logic [INSTR_W-1:0] instr_drv [2];
    logic               mr_drv    [2];
    logic               pcw [2], pcwc [2], iord [2], mrd [2], mwr [2];
    logic               irw [2], m2r [2], rw [2], rdst [2], srca [2];
    logic [1:0]         srcb [2], aop [2], pcs [2];
    logic               ill [2];
    logic [15:0]        cnt_a;
    logic [1:0]         cnt_b;
    logic [15:0]        ctrl_obs [2];
    logic [15:0]        cnt_obs  [2];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cnt_model [2];
    int   cnt_max   [2] = '{65535, 3};
    bit   en_addi   [2] = '{1'b1, 1'b0};
    bit   en_jump   [2] = '{1'b1, 1'b0};
    cyc_t trace [$];

    // Instance 0: default parameters. Instance 1: 2-bit counter, addi/j disabled.
    multicycle_control u_dut_a (
        .clk(clk), .rst_n(rst_n), .instrWord(instr_drv[0]), .mem_ready(mr_drv[0]),
        .PCWrite(pcw[0]), .PCWriteCond(pcwc[0]), .IorD(iord[0]), .MemRead(mrd[0]),
        .MemWrite(mwr[0]), .IRWrite(irw[0]), .MemToReg(m2r[0]), .RegWrite(rw[0]),
        .RegDest(rdst[0]), .ALUSrcA(srca[0]), .ALUSrcB(srcb[0]), .ALUOp(aop[0]),
        .PCSource(pcs[0]), .illegal(ill[0]), .instr_count(cnt_a)
    );

    multicycle_control #(.CNT_W(2), .EN_ADDI(1'b0), .EN_JUMP(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .instrWord(instr_drv[1]), .mem_ready(mr_drv[1]),
        .PCWrite(pcw[1]), .PCWriteCond(pcwc[1]), .IorD(iord[1]), .MemRead(mrd[1]),
        .MemWrite(mwr[1]), .IRWrite(irw[1]), .MemToReg(m2r[1]), .RegWrite(rw[1]),
        .RegDest(rdst[1]), .ALUSrcA(srca[1]), .ALUSrcB(srcb[1]), .ALUOp(aop[1]),
        .PCSource(pcs[1]), .illegal(ill[1]), .instr_count(cnt_b)
    );

    always_comb begin
        for (int k = 0; k < 2; k++)
            ctrl_obs[k] = {pcw[k], pcwc[k], iord[k], mrd[k], mwr[k], irw[k], m2r[k],
                           rw[k], rdst[k], srca[k], srcb[k], aop[k], pcs[k]};
        cnt_obs[0] = cnt_a;
        cnt_obs[1] = {14'd0, cnt_b};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cv(input bit pcw_e, pcwc_e, iord_e, mrd_e, mwr_e,
                                       irw_e, m2r_e, rw_e, rd_e, sa_e,
                                       input logic [1:0] sb_e, aop_e, pcs_e);
        return {pcw_e, pcwc_e, iord_e, mrd_e, mwr_e, irw_e, m2r_e, rw_e, rd_e, sa_e,
                sb_e, aop_e, pcs_e};
    endfunction

    task automatic push(input bit mr, input logic [15:0] c, input bit il);
        cyc_t e;
        e.mr = mr; e.ctrl = c; e.ill = il;
        trace.push_back(e);
    endtask

    function automatic logic [31:0] rand_word(input logic [5:0] opc);
        logic [25:0] low;
        low = 26'($urandom);
        return {opc, low};
    endfunction

    function automatic bit is_legal(input int d, input logic [5:0] opc);
        return opc == 6'b000000 || opc == 6'b100011 || opc == 6'b101011 ||
               opc == 6'b000100 || (opc == 6'b001000 && en_addi[d]) ||
               (opc == 6'b000010 && en_jump[d]);
    endfunction

    // Build the expected cycle trace of one instruction, then play it on DUT d.
    // Every call starts and ends just after a rising edge with the DUT in FETCH.
    task automatic run_instr(input int d, input logic [31:0] word, input int fwait,
                             input int mwait, input int stop_after, input int halt_cycles);
        logic [5:0] opc;
        bit         retires;
        int         exp_cnt;
        opc = word[31:26];
        retires = 1'b1;
        trace.delete();
        for (int i = 0; i < fwait; i++)
            push(1'b0, cv(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00), 1'b0);
        push(1'b1, cv(1,0,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00), 1'b0);
        push(1'($urandom), cv(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00), 1'b0);
        if (!is_legal(d, opc)) begin
            retires = 1'b0;
            for (int i = 0; i < halt_cycles; i++)
                push(1'($urandom), 16'h0000, 1'b1);
        end else if (opc == 6'b100011 || opc == 6'b101011) begin
            push(1'($urandom), cv(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00), 1'b0);
            for (int i = 0; i <= mwait; i++) begin
                if (opc == 6'b100011)
                    push(i == mwait, cv(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00), 1'b0);
                else
                    push(i == mwait, cv(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00), 1'b0);
            end
            if (opc == 6'b100011)
                push(1'($urandom), cv(0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00), 1'b0);
        end else if (opc == 6'b000000) begin
            push(1'($urandom), cv(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00), 1'b0);
            push(1'($urandom), cv(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00), 1'b0);
        end else if (opc == 6'b000100) begin
            push(1'($urandom), cv(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01), 1'b0);
        end else if (opc == 6'b000010) begin
            push(1'($urandom), cv(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10), 1'b0);
        end else begin
            push(1'($urandom), cv(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00), 1'b0);
            push(1'($urandom), cv(0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 2'b00), 1'b0);
        end

        instr_drv[d] = word;
        for (int i = 0; i < trace.size(); i++) begin
            if (stop_after >= 0 && i >= stop_after) break;
            mr_drv[d] = trace[i].mr;
            @(negedge clk);
            check($sformatf("dut%0d op%06b cyc%0d ctrl", d, opc, i), 32'(ctrl_obs[d]),
                  32'(trace[i].ctrl));
            check($sformatf("dut%0d op%06b cyc%0d illegal", d, opc, i), 32'(ill[d]),
                  32'(trace[i].ill));
            check($sformatf("dut%0d op%06b cyc%0d count", d, opc, i), 32'(cnt_obs[d]),
                  32'(cnt_model[d]));
            @(posedge clk);
            #1;
        end
        mr_drv[d] = 1'b0;
        if (stop_after < 0 && retires) begin
            exp_cnt = (cnt_model[d] == cnt_max[d]) ? cnt_model[d] : cnt_model[d] + 1;
            cnt_model[d] = exp_cnt;
            check($sformatf("dut%0d op%06b retired count", d, opc), 32'(cnt_obs[d]),
                  32'(exp_cnt));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s dut%0d ctrl", tag, k), 32'(ctrl_obs[k]), 32'h0);
            check($sformatf("%s dut%0d count", tag, k), 32'(cnt_obs[k]), 32'h0);
            check($sformatf("%s dut%0d illegal", tag, k), 32'(ill[k]), 32'h0);
        end
    endtask

    initial begin
        logic [5:0] opc;
        logic [5:0] legal_a [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                    6'b001000, 6'b000010};
        cnt_model = '{0, 0};
        rst_n = 1'b0;
        instr_drv[0] = '0;
        instr_drv[1] = '0;
        mr_drv[0] = 1'b1;
        mr_drv[1] = 1'b1;
        #12;
        check_reset_outputs("reset");
        mr_drv[0] = 1'b0;
        mr_drv[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed: lw, sw with a 3-cycle write wait, beq.
        run_instr(0, 32'h8C220004, 0, 0, -1, 0);
        run_instr(0, 32'hAC220004, 0, 3, -1, 0);
        run_instr(0, 32'h10220003, 0, 0, -1, 0);

        // Random mix with random fetch and data-memory wait states.
        for (int n = 0; n < 40; n++) begin
            opc = legal_a[$urandom_range(0, 5)];
            run_instr(0, rand_word(opc), $urandom_range(0, 3), $urandom_range(0, 3), -1, 0);
        end

        // Reset asserted while the lw sits in MEMRD waiting for memory.
        run_instr(0, 32'h8C220004, 0, 5, 5, 0);
        check("memrd before reset", 32'(mrd[0]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-memrd reset");
        cnt_model = '{0, 0};
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_instr(0, 32'h8C220004, 1, 0, -1, 0);

        // Small-counter instance: five R-types saturate at 3.
        for (int n = 0; n < 5; n++)
            run_instr(1, 32'h00221820, 0, 0, -1, 0);
        for (int n = 0; n < 8; n++) begin
            opc = legal_a[$urandom_range(0, 3)];
            run_instr(1, rand_word(opc), $urandom_range(0, 2), $urandom_range(0, 2), -1, 0);
        end
        // j with jumps disabled halts and stays halted.
        run_instr(1, 32'h08000010, 0, 0, -1, 10);

        // A random unsupported opcode halts the default instance.
        do opc = 6'($urandom); while (is_legal(0, opc));
        run_instr(0, rand_word(opc), $urandom_range(0, 2), 0, -1, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter INSTR_W, default 32: instruction word width.
REQ-002 Parameter OPC_LSB, default 26: opcode field is instrWord[INSTR_W-1:OPC_LSB] (6 bits).
REQ-003 Parameter CNT_W, default 16: retired-instruction counter width.
REQ-004 Parameter EN_ADDI, default 1: 1 enables addi (001000); 0 treats it as illegal.
REQ-005 Parameter EN_JUMP, default 1: 1 enables j (000010); 0 treats it as illegal.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 instrWord  input  INSTR_W  instruction register contents, stable from DECODE to end of instruction.
REQ-009 mem_ready  input  1  memory access completes this cycle.
REQ-010 PCWrite  output  1  unconditional PC load.
REQ-011 PCWriteCond  output  1  PC load if ALU zero.
REQ-012 IorD  output  1  0 = PC addresses memory, 1 = ALUOut.
REQ-013 MemRead  output  1  memory read request.
REQ-014 MemWrite  output  1  memory write request.
REQ-015 IRWrite  output  1  instruction register load.
REQ-016 MemToReg  output  1  write-back source: 1 = MDR, 0 = ALUOut.
REQ-017 RegWrite  output  1  register file write.
REQ-018 RegDest  output  1  1 = rd, 0 = rt.
REQ-019 ALUSrcA  output  1  0 = PC, 1 = reg A.
REQ-020 ALUSrcB  output  2  00 = reg B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
REQ-021 ALUOp  output  2  00 = add, 01 = sub, 10 = funct field.
REQ-022 PCSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target.
REQ-023 illegal  output  1  sticky unsupported-opcode flag.
REQ-024 instr_count  output  CNT_W  retired instructions, saturating.

Function
REQ-025 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, ADDI_EX, ADDI_WB, HALT.
REQ-026 Outputs not listed for a state are 0.
REQ-027 FETCH: MemRead=1, ALUSrcB=01. IRWrite=PCWrite=1 only in the cycle mem_ready=1, then go to DECODE; otherwise stay in FETCH.
REQ-028 DECODE: ALUSrcB=11. Next state by opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 001000->ADDI_EX, 000010->JUMP, anything else->HALT.
REQ-029 MEMADR: ALUSrcA=1, ALUSrcB=10; go to MEMRD for lw, MEMWR for sw.
REQ-030 MEMRD: MemRead=1, IorD=1; go to MEMWB on mem_ready, else hold. MEMWB: RegWrite=1, MemToReg=1, RegDest=0; go to FETCH.
REQ-031 MEMWR: MemWrite=1, IorD=1; go to FETCH on mem_ready, else hold with outputs unchanged.
REQ-032 EXEC: ALUSrcA=1, ALUOp=10; go to RWB. RWB: RegWrite=1, RegDest=1; go to FETCH.
REQ-033 BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01; go to FETCH. JUMP: PCWrite=1, PCSource=10; go to FETCH.
REQ-034 ADDI_EX: ALUSrcA=1, ALUSrcB=10; go to ADDI_WB. ADDI_WB: RegWrite=1, RegDest=0; go to FETCH.
REQ-035 HALT: all control outputs 0, illegal=1; no exit except reset.
REQ-036 A disabled opcode (EN_ADDI=0 or EN_JUMP=0) routes DECODE->HALT.
REQ-037 instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP or ADDI_WB, and holds at 2^CNT_W-1.
REQ-038 CPI per instruction with mem_ready tied to 1: lw 5, sw/R/addi 4, beq/j 3.

Reset
REQ-039 rst_n low: state=FETCH, instr_count=0, illegal=0, all control outputs forced to 0 asynchronously, including mid-instruction and during memory waits.
REQ-040 First rising edge after rst_n rises: FETCH behaviour per REQ-027.

Structure
REQ-041 Package mips_ctrl_pkg holds the opcode constants, the state encoding, and the ALUOp/ALUSrcB/PCSource codes.
REQ-042 The block is a single module with one next-state process and one output decode process; the saturating counter is inline and has no sub-module.

Verification
REQ-043 lw (0x8C220004) with mem_ready=1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1 and MemToReg=1 in cycle 5; instr_count 0->1.
REQ-044 sw with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 and IorD=1 held 4 cycles, then FETCH; count +1.
REQ-045 beq (0x10220003) -> PCWriteCond=1, ALUOp=01, PCSource=01 in cycle 3; j with EN_JUMP=0 -> HALT, illegal=1, persists 10 cycles.
REQ-046 rst_n driven low mid-MEMRD -> all outputs 0 immediately; after release, FETCH with MemRead=1.
REQ-047 CNT_W=2, 5 back-to-back R-type (0x00221820) -> instr_count 1,2,3,3,3.
